// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_loader.
// slave = loader side, master = stream source / memory / core side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              load_error;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_error
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: word-count header + big-endian instruction bytes -> imem writes, then releases the core.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  imem_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t             r_state, w_state_nxt;
  logic               r_byte_ready, r_imem_we, r_cpu_run, r_load_error;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [31:0]        r_imem_wdata;
  logic [7:0]         r_hdr_hi;
  logic [CNT_W-1:0]   r_nwords, r_word_cnt;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_shift;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         r_chk;
`endif

  logic               w_xfer, w_hdr_ovf, w_hdr_zero, w_word_end, w_last_word;
  logic [15:0]        w_hdr_n;
  logic               w_ready_nxt, w_we_nxt, w_run_nxt, w_err_nxt;

  assign w_xfer      = bus.byte_valid & r_byte_ready;
  assign w_hdr_n     = {r_hdr_hi, bus.byte_data};
  assign w_hdr_ovf   = 32'(w_hdr_n) > 32'(DEPTH);
  assign w_hdr_zero  = (w_hdr_n == 16'd0);
  assign w_word_end  = (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt == (r_nwords - CNT_W'(1)));

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_HDR_HI;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; every exit is taken on a transfer edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_state_nxt = S_HDR_LO;
      S_HDR_LO: if (w_xfer) begin
        if (w_hdr_ovf)       w_state_nxt = S_ERROR;
        else if (w_hdr_zero) w_state_nxt = S_FIN;
        else                 w_state_nxt = S_DATA;
      end
      S_DATA:   if (w_xfer && w_word_end && w_last_word) w_state_nxt = S_FIN;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    if (w_xfer) w_state_nxt = (bus.byte_data == r_chk) ? S_DONE : S_ERROR;
`endif
      default:  w_state_nxt = r_state;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ready_nxt = 1'b1;
    w_we_nxt    = 1'b0;
    w_run_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_state_nxt == S_DONE || w_state_nxt == S_ERROR) w_ready_nxt = 1'b0;
    if (r_state == S_DATA && w_xfer && w_word_end)       w_we_nxt    = 1'b1;
    if (r_state == S_DONE)                               w_run_nxt   = 1'b1;
    if (r_state == S_ERROR)                              w_err_nxt   = 1'b1;
  end

  // Output registers and word assembly; a reset drops any partial word
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_load_error <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_hdr_hi     <= '0;
      r_nwords     <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      r_byte_ready <= w_ready_nxt;
      r_imem_we    <= w_we_nxt;
      r_cpu_run    <= w_run_nxt;
      r_load_error <= w_err_nxt;
      if (w_xfer) begin
        case (r_state)
          S_HDR_HI: r_hdr_hi <= bus.byte_data;
          S_HDR_LO: begin
            r_nwords   <= CNT_W'(w_hdr_n);
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
          end
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], bus.byte_data};
`ifdef LOADER_CHECKSUM_EN
            r_chk      <= r_chk ^ bus.byte_data;
`endif
            if (w_word_end) begin
              r_word_cnt   <= r_word_cnt + CNT_W'(1);
              r_imem_addr  <= ADDR_W'(r_word_cnt);
              r_imem_wdata <= {r_shift, bus.byte_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.cpu_run    = r_cpu_run;
  assign bus.load_error = r_load_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random valid gaps, byte-level stream model, write scoreboard.
module tb_imem_loader;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b0;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe seen, as {addr, data}
  logic [63:0] got_wr[$];
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) got_wr.push_back({32'(bus.imem_addr), bus.imem_wdata});
  end

  // Reference model: what a stream should produce
  logic [63:0] exp_wr[$];
  int          exp_acc;
  logic        exp_done, exp_err;
  logic [7:0]  stim[$];
  logic [7:0]  chk_byte;

  task automatic model_stream(input logic [7:0] s[$]);
    int unsigned n;
    int          total;
    logic [7:0]  x;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_acc  = s.size();
    if (s.size() < 2) return;
    n = int'({s[0], s[1]});
    if (n > DEPTH) begin
      exp_err = 1'b1;
      exp_acc = 2;
      return;
    end
    for (int i = 0; i < int'(n); i++)
      if (5 + 4 * i < s.size())
        exp_wr.push_back({32'(i), s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
`ifdef LOADER_CHECKSUM_EN
    total = 2 + 4 * int'(n) + 1;
`else
    total = 2 + 4 * int'(n);
`endif
    if (s.size() >= total) begin
      exp_acc = total;
      x = 8'h00;
      for (int i = 2; i < 2 + 4 * int'(n); i++) x ^= s[i];
`ifdef LOADER_CHECKSUM_EN
      if (s[total-1] == x) exp_done = 1'b1;
      else                 exp_err  = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic build_stream(input logic [31:0] words[$], input int unsigned n_hdr, input bit bad_chk);
    logic [7:0] x;
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(n_hdr >> 8));
    stim.push_back(8'(n_hdr));
    foreach (words[i]) begin
      for (int b = 3; b >= 0; b--) begin
        logic [7:0] by;
        by = 8'(words[i] >> (8 * b));
        stim.push_back(by);
        x ^= by;
      end
    end
    chk_byte = x ^ {7'b0, bad_chk};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(chk_byte);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.ctl", {bus.byte_ready, bus.imem_we, bus.cpu_run, bus.load_error}, 4'b0000);
    check("rst.addr", 64'(bus.imem_addr), 64'd0);
    check("rst.wdata", 64'(bus.imem_wdata), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst.ready_rise", bus.byte_ready, 1'b1);
  endtask

  // Offer bytes (with random valid gaps) until n_want are accepted or budget expires
  task automatic drive(input logic [7:0] s[$], input int n_want, input int pct, output int n_acc);
    int   idx, cyc, budget;
    logic r, v;
    idx = 0;
    cyc = 0;
    budget = n_want * 300 / pct + 50;
    while (idx < n_want && cyc < budget) begin
      @(negedge clock);
      r = bus.byte_ready;
      v = ($urandom_range(99) < 32'(pct));
      bus.byte_valid = v;
      bus.byte_data  = v ? s[idx] : 8'($urandom);
      @(posedge clock);
      if (v && r) idx++;
      cyc++;
    end
    n_acc = idx;
  endtask

  task automatic run_case(input string name, input logic [7:0] s[$], input int pct, input bit with_rst);
    int acc, extra;
    if (with_rst) do_reset();
    got_wr.delete();
    model_stream(s);
    drive(s, exp_acc, pct, acc);
    check({name, ".accepted"}, 64'(acc), 64'(exp_acc));
    @(negedge clock);
    bus.byte_valid = 1'b0;
    check({name, ".run_late"}, {bus.cpu_run, bus.load_error}, 2'b00);
    check({name, ".ready_off"}, bus.byte_ready, 1'b0);
    @(negedge clock);
    check({name, ".run"}, bus.cpu_run, exp_done);
    check({name, ".err"}, bus.load_error, exp_err);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.byte_ready === 1'b1) extra++;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
    end
    @(negedge clock);
    bus.byte_valid = 1'b0;
    check({name, ".terminal_accepts"}, 64'(extra), 64'd0);
    check({name, ".run_hold"}, {bus.cpu_run, bus.load_error}, {exp_done, exp_err});
    check({name, ".n_writes"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check($sformatf("%s.wr%0d", name, i), got_wr[i], exp_wr[i]);
  endtask

  logic [31:0] wq[$];
  int          acc0;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    wq = '{32'h20080005, 32'hAC080000};
    build_stream(wq, 2, 1'b0);
    run_case("dir2", stim, 100, 1'b1);
    run_case("dir2_gaps", stim, 40, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    build_stream(wq, 2, 1'b1);
    run_case("bad_chk", stim, 100, 1'b1);
`endif

    wq.delete();
    build_stream(wq, 0, 1'b0);
    run_case("n0", stim, 100, 1'b1);

    stim = '{8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_case("n257", stim, 100, 1'b1);
    stim = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    run_case("nffff", stim, 70, 1'b1);

    wq.delete();
    for (int i = 0; i < int'(DEPTH); i++) wq.push_back($urandom);
    build_stream(wq, DEPTH, 1'b0);
    run_case("n256", stim, 100, 1'b1);

    // Abort after 6 data bytes, then replay the whole image
    wq = '{32'h20080005, 32'hAC080000};
    build_stream(wq, 2, 1'b0);
    do_reset();
    got_wr.delete();
    begin
      logic [7:0] pre[$];
      pre = stim[0:7];
      model_stream(pre);
      drive(pre, 8, 100, acc0);
      @(negedge clock);
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("abort.accepted", 64'(acc0), 64'd8);
      check("abort.n_writes", 64'(got_wr.size()), 64'(exp_wr.size()));
      if (got_wr.size() > 0) check("abort.wr0", got_wr[0], exp_wr[0]);
      check("abort.run", bus.cpu_run, 1'b0);
    end
    do_reset();
    check("abort.no_pulse", 64'(got_wr.size()), 64'd1);
    run_case("replay", stim, 100, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int unsigned n;
      n = $urandom_range(1, 12);
      wq.delete();
      for (int i = 0; i < int'(n); i++) wq.push_back($urandom);
      build_stream(wq, n, 1'b0);
      run_case($sformatf("rnd%0d", t), stim, int'($urandom_range(30, 100)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
